// File: rtl/s_pdiv_pe.sv
// s_pdiv_pe: dataflow PE with operand source muxing, a multi-cycle restoring divider,
// a small local register file and a programmable delay line.
module s_pdiv_pe #(
    parameter int unsigned N_BITS      = 32,
    parameter int unsigned N_NEIGH     = 4,
    parameter int unsigned RF_DEPTH    = 2,
    parameter int unsigned DELAY_DEPTH = 4,
    localparam int unsigned SEL_W = $clog2(N_NEIGH + 4),
    localparam int unsigned RFW   = $clog2(RF_DEPTH),
    localparam int unsigned DDW   = $clog2(DELAY_DEPTH + 1),
    localparam int unsigned CW    = 3 * SEL_W + 4 + 2 * RFW + DDW
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [CW-1:0]             ctrl_i,
    input  logic [N_BITS-1:0]         const_i,
    input  logic [N_NEIGH*N_BITS-1:0] neigh_op_i,
    input  logic [N_NEIGH-1:0]        neigh_valid_i,
    input  logic                      out_ready_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [N_BITS-1:0]         res_o,
    output logic [N_BITS-1:0]         aux_o,
    output logic [N_BITS-1:0]         delay_op_o,
    output logic                      delay_valid_o
);

    localparam int unsigned SA_LO  = 0;
    localparam int unsigned SB_LO  = SEL_W;
    localparam int unsigned OP_LO  = 2 * SEL_W;
    localparam int unsigned WE_BIT = 2 * SEL_W + 3;
    localparam int unsigned WI_LO  = WE_BIT + 1;
    localparam int unsigned RI_LO  = WI_LO + RFW;
    localparam int unsigned DS_LO  = RI_LO + RFW;
    localparam int unsigned DD_LO  = DS_LO + SEL_W;

    localparam int unsigned N_SRC  = N_NEIGH + 4;
    localparam int unsigned N_DSRC = N_NEIGH + 3;
    localparam int unsigned CNT_W  = $clog2(N_BITS);
    localparam int unsigned TAP_W  = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PASS = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REMU = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_REM  = 3'd5;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    logic [SEL_W-1:0] sel_a, sel_b, delay_sel;
    logic [2:0]       op;
    logic             rf_wr_en;
    logic [RFW-1:0]   rf_wr_idx, rf_rd_idx;
    logic [DDW-1:0]   delay_depth;

    assign sel_a       = ctrl_i[SA_LO +: SEL_W];
    assign sel_b       = ctrl_i[SB_LO +: SEL_W];
    assign op          = ctrl_i[OP_LO +: 3];
    assign rf_wr_en    = ctrl_i[WE_BIT];
    assign rf_wr_idx   = ctrl_i[WI_LO +: RFW];
    assign rf_rd_idx   = ctrl_i[RI_LO +: RFW];
    assign delay_sel   = ctrl_i[DS_LO +: SEL_W];
    assign delay_depth = ctrl_i[DD_LO +: DDW];

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_BITS-1:0]  quot_q, rem_q, dvsr_q;
    logic               qneg_q, rneg_q, is_rem_q;
    logic [N_BITS-1:0]  rf_q [RF_DEPTH];

    logic [N_BITS-1:0]  dl_data_q [DELAY_DEPTH];
    logic [DELAY_DEPTH-1:0] dl_valid_q;

    // Operand sources; self reads the registered result so there is no loop.
    logic [N_BITS-1:0]  src_data [N_SRC];
    logic [N_SRC-1:0]   src_valid;

    always_comb begin
        for (int i = 0; i < N_NEIGH; i++) begin
            src_data[i]  = neigh_op_i[i*N_BITS +: N_BITS];
            src_valid[i] = neigh_valid_i[i];
        end
        src_data[N_NEIGH]     = res_o;
        src_valid[N_NEIGH]    = valid_o;
        src_data[N_NEIGH+1]   = rf_q[rf_rd_idx];
        src_valid[N_NEIGH+1]  = 1'b1;
        src_data[N_NEIGH+2]   = const_i;
        src_valid[N_NEIGH+2]  = 1'b1;
        src_data[N_NEIGH+3]   = '0;
        src_valid[N_NEIGH+3]  = 1'b1;
    end

    logic [N_BITS-1:0] op_a, op_b;
    logic              valid_a, valid_b;

    always_comb begin
        op_a    = '0;
        valid_a = 1'b0;
        op_b    = '0;
        valid_b = 1'b0;
        if (32'(sel_a) < N_SRC) begin
            op_a    = src_data[sel_a];
            valid_a = src_valid[sel_a];
        end
        if (32'(sel_b) < N_SRC) begin
            op_b    = src_data[sel_b];
            valid_b = src_valid[sel_b];
        end
    end

    logic              op_nop, accept, is_signed, is_rem, a_neg, b_neg;
    logic [N_BITS-1:0] a_mag, b_mag;

    assign op_nop    = (op == OP_NOP) || (op > OP_REM);
    assign accept    = (state_q == StIdle) && !op_nop && valid_a && valid_b;
    assign is_signed = (op == OP_DIV) || (op == OP_REM);
    assign is_rem    = (op == OP_REMU) || (op == OP_REM);
    assign a_neg     = is_signed & op_a[N_BITS-1];
    assign b_neg     = is_signed & op_b[N_BITS-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;

    // One restoring step: shift the next dividend bit in, subtract, restore on borrow.
    logic [N_BITS:0]   trial;
    logic [N_BITS-1:0] rem_nxt, quot_nxt, q_fin, r_fin;

    assign trial    = {rem_q, quot_q[N_BITS-1]} - {1'b0, dvsr_q};
    assign rem_nxt  = trial[N_BITS] ? {rem_q[N_BITS-2:0], quot_q[N_BITS-1]}
                                    : trial[N_BITS-1:0];
    assign quot_nxt = {quot_q[N_BITS-2:0], ~trial[N_BITS]};
    assign q_fin    = qneg_q ? -quot_nxt : quot_nxt;
    assign r_fin    = rneg_q ? -rem_nxt : rem_nxt;

    assign ready_o = (state_q == StIdle);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
            valid_o  <= 1'b0;
            res_o    <= '0;
            aux_o    <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (op_nop) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_o <= 1'b0;
            res_o   <= '0;
            aux_o   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (op == OP_PASS) begin
                            state_q <= StDone;
                            valid_o <= 1'b1;
                            res_o   <= op_a;
                            aux_o   <= '0;
                        end else if (op_b == '0) begin
                            // Divide by zero: quotient all-ones, remainder is the dividend.
                            state_q <= StDone;
                            valid_o <= 1'b1;
                            res_o   <= is_rem ? op_a : '1;
                            aux_o   <= is_rem ? '1 : op_a;
                        end else begin
                            state_q  <= StCalc;
                            cnt_q    <= CNT_W'(N_BITS - 1);
                            quot_q   <= a_mag;
                            rem_q    <= '0;
                            dvsr_q   <= b_mag;
                            qneg_q   <= a_neg ^ b_neg;
                            rneg_q   <= a_neg;
                            is_rem_q <= is_rem;
                        end
                    end
                end
                StCalc: begin
                    quot_q <= quot_nxt;
                    rem_q  <= rem_nxt;
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                        valid_o <= 1'b1;
                        res_o   <= is_rem_q ? r_fin : q_fin;
                        aux_o   <= is_rem_q ? q_fin : r_fin;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q <= StIdle;
                        valid_o <= 1'b0;
                        if (rf_wr_en) begin
                            rf_q[rf_wr_idx] <= res_o;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [N_BITS-1:0] dsrc_arr [N_DSRC];
    logic [N_DSRC-1:0] dsrc_vld;
    logic [N_BITS-1:0] dsrc_data;
    logic              dsrc_valid;

    always_comb begin
        for (int i = 0; i < N_NEIGH; i++) begin
            dsrc_arr[i] = neigh_op_i[i*N_BITS +: N_BITS];
            dsrc_vld[i] = neigh_valid_i[i];
        end
        dsrc_arr[N_NEIGH]   = op_a;
        dsrc_vld[N_NEIGH]   = valid_a;
        dsrc_arr[N_NEIGH+1] = op_b;
        dsrc_vld[N_NEIGH+1] = valid_b;
        dsrc_arr[N_NEIGH+2] = res_o;
        dsrc_vld[N_NEIGH+2] = valid_o;
        dsrc_data  = '0;
        dsrc_valid = 1'b0;
        if (32'(delay_sel) < N_DSRC) begin
            dsrc_data  = dsrc_arr[delay_sel];
            dsrc_valid = dsrc_vld[delay_sel];
        end
    end

    // The delay line advances only while downstream is accepting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DELAY_DEPTH; i++) begin
                dl_data_q[i]  <= '0;
                dl_valid_q[i] <= 1'b0;
            end
        end else if (out_ready_i) begin
            dl_data_q[0]  <= dsrc_data;
            dl_valid_q[0] <= dsrc_valid;
            for (int i = 1; i < DELAY_DEPTH; i++) begin
                dl_data_q[i]  <= dl_data_q[i-1];
                dl_valid_q[i] <= dl_valid_q[i-1];
            end
        end
    end

    logic [TAP_W-1:0] tap_idx;

    always_comb begin
        if (delay_depth == '0) begin
            tap_idx = '0;
        end else if (delay_depth > DDW'(DELAY_DEPTH)) begin
            tap_idx = TAP_W'(DELAY_DEPTH - 1);
        end else begin
            tap_idx = TAP_W'(delay_depth - DDW'(1));
        end
        delay_op_o    = dl_data_q[tap_idx];
        delay_valid_o = dl_valid_q[tap_idx];
    end

endmodule

// File: tb/tb_s_pdiv_pe.sv
// Directed, table-driven bench for s_pdiv_pe with hand-computed divider results,
// plus hand sequences for stall/RF, reset-in-CALC and delay-line taps.
module tb_s_pdiv_pe;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PASS = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REMU = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_REM  = 3'd5;

    localparam logic [2:0] S_N0    = 3'd0;
    localparam logic [2:0] S_RF    = 3'd5;
    localparam logic [2:0] S_CONST = 3'd6;
    localparam logic [2:0] S_ZERO  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] ctrl;
    logic [31:0] cst;
    logic [31:0] nb [4];
    logic [3:0]  nv;
    logic [127:0] nb_bus;
    logic        out_ready;
    logic        ready_o, valid_o, delay_valid_o;
    logic [31:0] res_o, aux_o, delay_op_o;

    int total = 0;
    int bad = 0;

    assign nb_bus = {nb[3], nb[2], nb[1], nb[0]};

    always #5 clk = ~clk;

    s_pdiv_pe dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .ctrl_i        (ctrl),
        .const_i       (cst),
        .neigh_op_i    (nb_bus),
        .neigh_valid_i (nv),
        .out_ready_i   (out_ready),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .res_o         (res_o),
        .aux_o         (aux_o),
        .delay_op_o    (delay_op_o),
        .delay_valid_o (delay_valid_o)
    );

    function automatic logic [17:0] mk_ctrl(input logic [2:0] sa, input logic [2:0] sb,
                                            input logic [2:0] op, input logic we,
                                            input logic wi, input logic ri,
                                            input logic [2:0] ds, input logic [2:0] dd);
        return {dd, ds, ri, wi, we, op, sb, sa};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Waits for the accept edge, then counts negedges until valid_o (0 = timeout).
    task automatic wait_valid(output int lat, output int rdy_low,
                              output logic [31:0] r, output logic [31:0] x);
        lat = 0;
        rdy_low = 0;
        r = '0;
        x = '0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!ready_o) rdy_low++;
            if (valid_o) begin
                lat = i;
                r = res_o;
                x = aux_o;
                break;
            end
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hs_valid", 32'(valid_o), 32'd0);
        check("hs_ready", 32'(ready_o), 32'd1);
        ctrl = mk_ctrl(S_ZERO, S_ZERO, OP_NOP, 1'b0, 1'b0, 1'b0, S_ZERO, 3'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic delay_run(input logic [2:0] dd, input int lag);
        logic [31:0] hist [12];
        ctrl = mk_ctrl(S_ZERO, S_ZERO, OP_NOP, 1'b0, 1'b0, 1'b0, 3'd2, dd);
        nv[2] = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k >= lag) begin
                check("dly_op", delay_op_o, hist[k-lag]);
                check("dly_vld", 32'(delay_valid_o), 32'd1);
            end
            hist[k] = 32'h0D00_0000 + (32'(dd) << 8) + 32'(k);
            nb[2] = hist[k];
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] aux;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int lat, rdy_low, spurious;
        logic [31:0] r, x;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          32'd14,         33};
        vecs[2]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  33};
        vecs[3]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[4]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
        vecs[5]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[6]  = '{OP_PASS, 32'h1234_5678,  32'd9,          32'h1234_5678,  32'd0,          1};
        vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
        vecs[8]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  1};
        vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[10] = '{OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          32'h1999_9999,  33};
        vecs[11] = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33};
        vecs[12] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  33};

        ctrl = mk_ctrl(S_ZERO, S_ZERO, OP_NOP, 1'b0, 1'b0, 1'b0, S_ZERO, 3'd1);
        cst = '0;
        for (int i = 0; i < 4; i++) nb[i] = '0;
        nv = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_res", res_o, 32'd0);
        check("rst_aux", aux_o, 32'd0);
        check("rst_dly_op", delay_op_o, 32'd0);
        check("rst_dly_vld", 32'(delay_valid_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            ctrl = mk_ctrl(S_CONST, S_N0, vecs[v].op, 1'b0, 1'b0, 1'b0, S_ZERO, 3'd1);
            cst = vecs[v].a;
            nb[0] = vecs[v].b;
            nv[0] = 1'b1;
            out_ready = 1'b1;
            wait_valid(lat, rdy_low, r, x);
            check($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("v%0d_rdy_low", v), 32'(rdy_low), 32'(vecs[v].lat));
            check($sformatf("v%0d_res", v), r, vecs[v].res);
            check($sformatf("v%0d_aux", v), x, vecs[v].aux);
            finish_op();
        end

        // Stall in DONE with the delay line frozen, then RF write-back and read.
        ctrl = mk_ctrl(S_ZERO, S_ZERO, OP_NOP, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1);
        nb[1] = 32'hAAAA_0001;
        nv[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_dly", delay_op_o, 32'hAAAA_0001);
        ctrl = mk_ctrl(S_CONST, S_N0, OP_DIVU, 1'b1, 1'b1, 1'b0, 3'd1, 3'd1);
        cst = 32'd100;
        nb[0] = 32'd7;
        nb[1] = 32'h5555_0000;
        out_ready = 1'b0;
        wait_valid(lat, rdy_low, r, x);
        check("stall_lat", 32'(lat), 32'd33);
        check("stall_res0", r, 32'd14);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(valid_o), 32'd1);
            check("stall_res", res_o, 32'd14);
            check("stall_aux", aux_o, 32'd2);
            check("stall_ready", 32'(ready_o), 32'd0);
            check("stall_dly", delay_op_o, 32'hAAAA_0001);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hs_ready_rf", 32'(ready_o), 32'd1);
        ctrl = mk_ctrl(S_RF, S_ZERO, OP_PASS, 1'b0, 1'b0, 1'b1, S_ZERO, 3'd1);
        wait_valid(lat, rdy_low, r, x);
        check("rf_lat", 32'(lat), 32'd1);
        check("rf_read", r, 32'd14);
        check("rf_aux", x, 32'd0);
        finish_op();

        // Reset during CALC, then NOP: nothing may come out.
        ctrl = mk_ctrl(S_CONST, S_N0, OP_DIVU, 1'b0, 1'b0, 1'b0, S_ZERO, 3'd1);
        cst = 32'd100;
        nb[0] = 32'd7;
        out_ready = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        check("calc_busy", 32'(ready_o), 32'd0);
        rst_n = 1'b0;
        ctrl = mk_ctrl(S_ZERO, S_ZERO, OP_NOP, 1'b0, 1'b0, 1'b0, S_ZERO, 3'd1);
        #1;
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_res", res_o, 32'd0);
        check("mid_rst_aux", aux_o, 32'd0);
        check("mid_rst_dly", delay_op_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid_o || !ready_o) spurious++;
        end
        check("no_spurious", 32'(spurious), 32'd0);
        check("post_res", res_o, 32'd0);
        check("post_dly_vld", 32'(delay_valid_o), 32'd0);

        delay_run(3'd3, 3);
        delay_run(3'd0, 1);
        delay_run(3'd7, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
